// File: rtl/gb_lcd_capture.sv
// Game Boy LCD stream capture: turns vs/hs/valid pixel traffic into addressed
// frame-buffer write requests, buffered in a small req/ack FIFO, with geometry checks.
module gb_lcd_capture #(
  parameter int unsigned H_ACTIVE    = 160,
  parameter int unsigned V_ACTIVE    = 144,
  parameter logic [22:0] BASE_ADDR   = 23'h010000,
  parameter int unsigned LINE_STRIDE = 320,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic [14:0] color_pixel,
  input  logic        vs,
  input  logic        hs,
  input  logic        valid,
  output logic        wr_req,
  output logic [22:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  output logic        new_line,
  output logic        frame_done,
  output logic        overflow_err,
  output logic        geom_err,
  input  logic        clr_err
);
  localparam int unsigned PW = $clog2(H_ACTIVE + 1);
  localparam int unsigned LW = $clog2(V_ACTIVE + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [22:0] STRIDE = 23'(LINE_STRIDE);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t        state;
  logic          vs_d, hs_d;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [22:0]   line_base;
  logic [38:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        vs_rise, hs_fall, active, pixel_slot, push_try, push, pop, full;
  logic        ovf_ev, geom_ev;
  logic [22:0] pix_addr;

  // vs edge outranks hs edge, which outranks a pixel in the same cycle
  always_comb begin
    vs_rise    = vs & ~vs_d;
    hs_fall    = hs_d & ~hs;
    active     = (state == ACTIVE);
    pixel_slot = active & ~vs_rise & ~hs_fall & valid & (line_cnt < LW'(V_ACTIVE));
    push_try   = pixel_slot & (pix_cnt < PW'(H_ACTIVE));
    pop        = wr_req & wr_ack;
    full       = (count == CW'(FIFO_DEPTH));
    push       = push_try & (~full | pop);
    ovf_ev     = push_try & full & ~pop;
    geom_ev    = (pixel_slot & (pix_cnt >= PW'(H_ACTIVE)))
               | (active & ~vs_rise & hs_fall & (pix_cnt != '0) & (pix_cnt != PW'(H_ACTIVE)));
    pix_addr   = line_base + 23'({pix_cnt, 1'b0});
  end

  assign wr_req  = (count != '0);
  assign wr_addr = mem[rd_ptr][38:16];
  assign wr_data = mem[rd_ptr][15:0];

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state        <= SYNC;
      vs_d         <= 1'b0;
      hs_d         <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      line_base    <= BASE_ADDR;
      new_line     <= 1'b0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
      geom_err     <= 1'b0;
    end else begin
      vs_d         <= vs;
      hs_d         <= hs;
      new_line     <= 1'b0;
      frame_done   <= 1'b0;
      overflow_err <= (overflow_err & ~clr_err) | ovf_ev;
      geom_err     <= (geom_err & ~clr_err) | geom_ev;
      case (state)
        SYNC: begin
          if (vs_rise) begin
            state     <= ACTIVE;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            line_base <= BASE_ADDR;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done <= (line_cnt == LW'(V_ACTIVE));
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_base  <= BASE_ADDR;
          end else if (hs_fall) begin
            if (pix_cnt != '0) begin
              pix_cnt   <= '0;
              if (line_cnt < LW'(V_ACTIVE)) line_cnt <= line_cnt + LW'(1);
              line_base <= line_base + STRIDE;
              new_line  <= 1'b1;
            end
          end else if (push_try) begin
            // advances even when the FIFO drops the pixel, keeping later addresses aligned
            pix_cnt <= pix_cnt + PW'(1);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {pix_addr, 1'b0, color_pixel};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule
